// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard for the in-order pipeline, placed beside ID.
// Each architectural register has a countdown counter. The counter holds the
// number of cycles left before that register's pending result can be
// forwarded to an instruction in ID. stall_o drives the PC/IF-ID write-enable
// and the ID/EX bubble mux.
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cnt_o
// performance counter.
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W         = 5,
  parameter int unsigned LAT_W              = 3,
  parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ID_valid_i,
  input  logic [REG_ADDR_W-1:0] ID_rsAddr_i,
  input  logic [REG_ADDR_W-1:0] ID_rtAddr_i,
  input  logic                  ID_rsUsed_i,
  input  logic                  ID_rtUsed_i,
  input  logic                  ID_regWrite_i,
  input  logic [REG_ADDR_W-1:0] ID_wbAddr_i,
  input  logic [LAT_W-1:0]      ID_lat_i,
  input  logic                  flush_i,
  input  logic                  freeze_i,
  output logic                  stall_o,
  output logic                  busy_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam int unsigned NumRegs = 1 << REG_ADDR_W;

  logic [LAT_W-1:0] cnt_q [NumRegs];
  logic [LAT_W-1:0] cnt_d [NumRegs];

  logic rs_haz;
  logic rt_haz;
  logic issue;

  // Counter minus one, saturating at zero.
  function automatic logic [LAT_W-1:0] dec_sat(input logic [LAT_W-1:0] v);
    return (v == '0) ? '0 : v - LAT_W'(1);
  endfunction

  // Hazard detection against the current counters, and issue qualification.
  always_comb begin
    rs_haz  = ID_rsUsed_i && (cnt_q[ID_rsAddr_i] != '0) &&
              !(ZERO_REG_HARDWIRED && (ID_rsAddr_i == '0));
    rt_haz  = ID_rtUsed_i && (cnt_q[ID_rtAddr_i] != '0) &&
              !(ZERO_REG_HARDWIRED && (ID_rtAddr_i == '0));
    stall_o = ID_valid_i && !flush_i && (rs_haz || rt_haz);
    // A self-dependent instruction is judged on the old counters above, so its
    // own write never feeds back into its stall.
    issue   = ID_valid_i && !stall_o && !flush_i && !freeze_i && ID_regWrite_i &&
              (ID_lat_i != '0) && !(ZERO_REG_HARDWIRED && (ID_wbAddr_i == '0));
  end

  // Next counter values: hold on freeze, else count down and merge a new issue.
  always_comb begin
    for (int r = 0; r < NumRegs; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!freeze_i) begin
        cnt_d[r] = dec_sat(cnt_q[r]);
        // Keep the longer of the pending and new latency so a short WAW write
        // never hides an older, longer one.
        if (issue && (ID_wbAddr_i == REG_ADDR_W'(r)) && (ID_lat_i > dec_sat(cnt_q[r]))) begin
          cnt_d[r] = ID_lat_i;
        end
      end
    end
  end

  // Counter state; reset drops all pending entries immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NumRegs; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NumRegs; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Any pending write keeps the scoreboard busy.
  always_comb begin
    busy_o = 1'b0;
    for (int r = 0; r < NumRegs; r++) begin
      busy_o = busy_o | (cnt_q[r] != '0);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count non-frozen stall cycles, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_o && !freeze_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  // Performance counter not built.
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal
// expectations plus randomized traffic checked against a ready-time model.
module tb_hazard_scoreboard;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned LatW     = 3;
  localparam int unsigned NumRegs  = 1 << RegAddrW;

  logic                clk = 1'b0;
  logic                rst_i = 1'b0;
  logic                valid = 1'b0;
  logic [RegAddrW-1:0] rs = '0;
  logic [RegAddrW-1:0] rt = '0;
  logic                rsu = 1'b0;
  logic                rtu = 1'b0;
  logic                rw = 1'b0;
  logic [RegAddrW-1:0] wb = '0;
  logic [LatW-1:0]     lat = '0;
  logic                flush = 1'b0;
  logic                freeze = 1'b0;
  logic                stall;
  logic                busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]         stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model: a write is pending on register r while the count of non-frozen
  // cycles elapsed (tick) is below ready[r].
  longint tick = 0;
  longint ready [NumRegs];
  longint perf_exp = 0;

  hazard_scoreboard #(
    .REG_ADDR_W        (RegAddrW),
    .LAT_W             (LatW),
    .ZERO_REG_HARDWIRED(1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .ID_valid_i   (valid),
    .ID_rsAddr_i  (rs),
    .ID_rtAddr_i  (rt),
    .ID_rsUsed_i  (rsu),
    .ID_rtUsed_i  (rtu),
    .ID_regWrite_i(rw),
    .ID_wbAddr_i  (wb),
    .ID_lat_i     (lat),
    .flush_i      (flush),
    .freeze_i     (freeze),
    .stall_o      (stall),
    .busy_o       (busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit pending(input int r);
    return (r != 0) && (ready[r] > tick);
  endfunction

  function automatic bit model_stall();
    return valid && !flush && ((rsu && pending(int'(rs))) || (rtu && pending(int'(rt))));
  endfunction

  function automatic bit model_busy();
    for (int r = 0; r < NumRegs; r++) if (pending(r)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NumRegs; r++) ready[r] = 0;
    perf_exp = 0;
  endtask

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model update at every rising edge, using the inputs held since the falling edge.
  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (rst_i) begin
        bit st;
        bit iss;
        st  = model_stall();
        iss = valid && !st && !flush && !freeze && rw && (lat != 0) && (wb != 0);
        if (!freeze) begin
          if (st) perf_exp++;
          if (iss && (ready[wb] < tick + lat + 1)) ready[wb] = tick + lat + 1;
          tick++;
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("stall_model", stall, model_stall());
      chk("busy_model", busy, model_busy());
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt_model", stall_cnt, perf_exp);
`endif
    end
  end

  task automatic cyc(input bit v, input int a_rs, input int a_rt, input bit u_rs, input bit u_rt,
                     input bit w, input int a_wb, input int l, input bit fl, input bit fz);
    @(negedge clk);
    valid  = v;
    rs     = RegAddrW'(a_rs);
    rt     = RegAddrW'(a_rt);
    rsu    = u_rs;
    rtu    = u_rt;
    rw     = w;
    wb     = RegAddrW'(a_wb);
    lat    = LatW'(l);
    flush  = fl;
    freeze = fz;
    #3;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset held: reading r5 must not stall.
    cyc(1, 5, 5, 1, 1, 0, 0, 0, 0, 0);
    chk("reset_stall", stall, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    rst_i = 1'b1;

    // Asynchronous reset mid-operation drops cnt[5] = 3.
    cyc(1, 0, 0, 0, 0, 1, 5, 3, 0, 0);
    cyc(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("r5_pending_stall", stall, 1);
    chk("r5_pending_busy", busy, 1);
    rst_i = 1'b0;
    model_clear();
    #1;
    chk("async_reset_busy", busy, 0);
    chk("async_reset_stall", stall, 0);
    @(negedge clk);
    rst_i = 1'b1;
    cyc(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("after_reset_r5", stall, 0);

    // Load-use: one stall cycle.
    cyc(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    chk("lw_issue", stall, 0);
    cyc(1, 8, 1, 1, 1, 1, 9, 0, 0, 0);
    chk("load_use_t1", stall, 1);
    cyc(1, 8, 1, 1, 1, 1, 9, 0, 0, 0);
    chk("load_use_t2", stall, 0);
    chk("load_use_busy", busy, 0);

    // Latency 4 with one frozen cycle: stall t+1..t+5.
    cyc(1, 0, 0, 0, 0, 1, 3, 4, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 3, 0, 1, 0, 0, 0, 0, 0, (i == 2));
      chk($sformatf("freeze_stall_t%0d", i), stall, 1);
    end
    cyc(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("freeze_proceed", stall, 0);

    // Unused source flag hides a pending register.
    cyc(1, 0, 0, 0, 0, 1, 6, 2, 0, 0);
    cyc(1, 6, 6, 0, 0, 0, 0, 0, 0, 0);
    chk("unused_src", stall, 0);
    idle();

    // WAW: lat 4 then lat 1 to r9 leaves 3 stall cycles for a reader.
    cyc(1, 0, 0, 0, 0, 1, 9, 4, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 9, 0, 1, 0, 0, 0, 0, 0);
      chk($sformatf("waw_stall_%0d", i), stall, 1);
    end
    cyc(1, 0, 9, 0, 1, 0, 0, 0, 0, 0);
    chk("waw_proceed", stall, 0);

    // Zero register never tracked; flushed write never issues.
    cyc(1, 0, 0, 0, 0, 1, 0, 2, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("zero_busy", busy, 0);
    chk("zero_stall", stall, 0);
    cyc(1, 0, 0, 0, 0, 1, 7, 2, 1, 0);
    cyc(1, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("flush_busy", busy, 0);
    chk("flush_stall", stall, 0);

    // Flush masks stall of a hazardous instruction.
    cyc(1, 0, 0, 0, 0, 1, 2, 2, 0, 0);
    cyc(1, 2, 0, 1, 0, 0, 0, 0, 1, 0);
    chk("flush_masks_stall", stall, 0);
    idle();
    idle();

    // Self-dependent instruction issues, then the next reader stalls.
    cyc(1, 4, 0, 1, 0, 1, 4, 2, 0, 0);
    chk("self_dep", stall, 0);
    cyc(1, 4, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("self_dep_next", stall, 1);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 6) == 0));
      if ($urandom_range(0, 499) == 0) begin
        rst_i = 1'b0;
        model_clear();
        #1;
        chk("rand_reset_busy", busy, 0);
        @(negedge clk);
        rst_i = 1'b1;
      end
    end

    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register-hazard scoreboard for the in-order pipeline, replacing the single-cycle load-use check between ID and EX. It holds one countdown counter per architectural register. Each counter records how many more cycles must pass before that register's pending result can be forwarded to an instruction in ID. A per-instruction latency class generalises load-use detection to any producer latency (loads, multi-cycle multiply, long-latency memory). The block sits beside the ID stage; its stall output drives the PC/IF-ID write-enable and the ID/EX bubble mux.

## Interface
- REG_ADDR_W, 5, register-address width; the register file holds 2^REG_ADDR_W entries.
- LAT_W, 3, width of the latency field and of each per-register counter.
- ZERO_REG_HARDWIRED, 1, when 1, register 0 is never tracked and never causes a stall.

Ports (clock and reset first):
- clk_i  input  1  pipeline clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset; clears every counter immediately.
- ID_valid_i  input  1  ID holds a real instruction, not a bubble.
- ID_rsAddr_i  input  REG_ADDR_W  source register rs.
- ID_rtAddr_i  input  REG_ADDR_W  source register rt.
- ID_rsUsed_i  input  1  the instruction actually reads rs.
- ID_rtUsed_i  input  1  the instruction actually reads rt.
- ID_regWrite_i  input  1  the instruction writes a register.
- ID_wbAddr_i  input  REG_ADDR_W  destination register.
- ID_lat_i  input  LAT_W  forwarding latency class: 0 = ALU (no hazard), 1 = load, n = result forwardable n cycles after issue.
- flush_i  input  1  the ID instruction is squashed this cycle (branch taken).
- freeze_i  input  1  whole pipeline frozen (memory busy); counters hold.
- stall_o  output  1  hazard detected; hold PC and IF/ID, inject bubble into ID/EX.
- busy_o  output  1  at least one counter is non-zero.

## Operation
- State: cnt[r] for each register r, LAT_W bits each.
- Hazard (combinational):
  - A source register is hazardous when its used flag is set and its counter is non-zero.
  - stall_o = ID_valid_i & ~flush_i & (rs hazardous | rt hazardous).
  - With ZERO_REG_HARDWIRED = 1, address 0 is never hazardous.
- Issue:
  - issue = ID_valid_i & ~stall_o & ~flush_i & ~freeze_i & ID_regWrite_i & (ID_lat_i != 0), excluding register 0 when it is hardwired.
- Per-cycle update when freeze_i = 0, for each register r:
  - dec = (cnt[r] == 0) ? 0 : cnt[r] − 1.
  - If issue targets r: cnt[r] <= max(dec, ID_lat_i). This covers WAW: a shorter new latency never hides an older, longer pending write.
  - Otherwise: cnt[r] <= dec. Counters saturate at 0 and never wrap.
- When freeze_i = 1: all counters hold, and no issue is accepted. stall_o is still computed.
- flush_i blocks the issue of the ID instruction only. Older in-flight entries are kept.
- A self-dependent instruction (source equals destination) is checked against the old counter value. Its own issue never stalls it.
- busy_o = OR of all counters.

## Timing
- Reset: all counters 0, so stall_o = 0 and busy_o = 0 from reset assertion onward. This holds asynchronously, even mid-operation; pending entries are lost.
- stall_o and busy_o have zero latency from inputs and counter state (combinational); counters have one-cycle latency.
- Load (lat 1) issued at cycle t: a dependent instruction in ID at t+1 sees stall_o = 1. At t+2 it sees 0 and proceeds, with MEM→EX forwarding assumed.
- Latency n issued at cycle t: a dependent instruction stalls in cycles t+1 … t+n and proceeds at t+n+1, plus one cycle for each cycle freeze_i is high.
- During a stall the same ID instruction is re-evaluated every cycle. It issues only in the first cycle where stall_o = 0.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds output stall_cnt_o [31:0], which counts cycles with stall_o = 1 and freeze_i = 0.
  - The count saturates at 0xFFFFFFFF and resets to 0.
- HAZARD_PERF_CNT_EN undefined: neither the port nor the counter exists. All other behaviour is identical.

## Test plan
- Reset mid-operation: set cnt[5] = 3, then assert rst_i low asynchronously → busy_o = 0 and stall_o = 0 in the same cycle; a read of r5 after release does not stall.
- Load-use: lw $8 (lat 1) issues at t; add reading $8 sits in ID at t+1 → stall_o = 1 for exactly one cycle, 0 at t+2.
- Long latency with freeze: lat-4 write to $3 issues at t; freeze_i = 1 during t+2 → a $3 reader stalls in cycles t+1 through t+5 (5 cycles), then proceeds.
- WAW keeps max: lat-4 write to $9 issues at t, lat-1 write to $9 issues at t+1 → cnt[9] = 3 at t+2; a $9 reader stalls until cnt reaches 0.
- Zero register and flush: lat-2 write to $0 → busy_o stays 0; lat-2 write to $7 with flush_i = 1 → cnt[7] stays 0.
- With HAZARD_PERF_CNT_EN: three load-use stalls → stall_cnt_o = 3; frozen stall cycles are not counted.
